hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised load-use hazard and stall controller for the 5-stage pipelined MIPS core; sits beside the ID stage and drives PC, IF/ID and ID/EX control.
- Extends single-bubble load-use detection with:
  - configurable load-to-use latency, counted by an FSM;
  - a global freeze while data memory is not ready;
  - taken-branch IF/ID flush;
  - Rt-use qualification, so I-type instructions cause no false stalls.

Parameters:
- REG_ADDR_W, 5, register-specifier width; register 0 is never a hazard source.
- LOAD_LATENCY, 1, total bubbles per load-use hazard; legal range 1..15.
- CNT_W, 4, width of the bubble down-counter; must hold LOAD_LATENCY-1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemReadEx  input  1  instruction in EX is a load.
- IDEX_Rt  input  REG_ADDR_W  destination of the load in EX.
- ID_Rs  input  REG_ADDR_W  Rs of the instruction in ID.
- ID_Rt  input  REG_ADDR_W  Rt of the instruction in ID.
- ID_UsesRt  input  1  instruction in ID reads Rt as a source.
- BranchTakenID  input  1  branch resolved taken in ID this cycle.
- MemReqMem  input  1  load or store active in MEM.
- MemReadyMem  input  1  data memory completes the MEM access this cycle.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register write enable.
- HazardMux  output  1  selects zeroed controls into ID/EX (bubble).
- IFIDFlush  output  1  clear IF/ID to NOP.
- PipeFreeze  output  1  hold ID/EX, EX/MEM and MEM/WB registers.

Behaviour:
- Reset:
  - State RUN, counter 0.
  - While reset is high, outputs are forced to PCWrite=1, IFIDWrite=1, HazardMux=0, IFIDFlush=0, PipeFreeze=0, regardless of inputs.
  - Reset asserted mid-stall returns to RUN immediately, asynchronously.
- Signals:
  - freeze = MemReqMem & ~MemReadyMem.
  - hit = MemReadEx & (IDEX_Rt != 0) & ((IDEX_Rt == ID_Rs) | (ID_UsesRt & (IDEX_Rt == ID_Rt))).
- Priority: freeze > load-use stall > branch flush.
- freeze=1 (any state):
  - PipeFreeze=1, PCWrite=0, IFIDWrite=0, HazardMux=0, IFIDFlush=0.
  - State and counter hold.
- State RUN, no freeze:
  - hit=1: PCWrite=0, IFIDWrite=0, HazardMux=1 (combinational, same cycle).
    - If LOAD_LATENCY>1, go to LU_STALL with counter=LOAD_LATENCY-1 on the next edge.
    - If LOAD_LATENCY=1, stay in RUN.
  - hit=0: PCWrite=1, IFIDWrite=1, HazardMux=0; IFIDFlush=BranchTakenID.
- State LU_STALL, no freeze:
  - Outputs PCWrite=0, IFIDWrite=0, HazardMux=1, IFIDFlush=0; hit is ignored.
  - BranchTakenID is ignored, because operands are not yet valid.
  - Counter decrements each non-frozen cycle; in the cycle counter==1, the next state is RUN with counter 0.
- Bubble count:
  - Exactly LOAD_LATENCY bubbles enter ID/EX per hazard.
  - Freeze cycles in between add no bubbles and consume no count.
- Back-to-back: a new hit on the first RUN cycle after LU_STALL starts a new, full stall sequence.
- All outputs are combinational from state, counter and inputs; no output registers.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCycles[31:0] and FreezeCycles[31:0], both saturating at 0xFFFFFFFF and cleared by reset.
  - StallCycles increments in each cycle with HazardMux=1.
  - FreezeCycles increments in each cycle with PipeFreeze=1.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- LOAD_LATENCY=1, MemReadEx=1, IDEX_Rt=8, ID_Rs=8 -> same cycle PCWrite=0, IFIDWrite=0, HazardMux=1; next cycle, with MemReadEx=0, outputs back to 1,1,0.
- IDEX_Rt=0=ID_Rs with MemReadEx=1 -> no stall. IDEX_Rt=9=ID_Rt with ID_UsesRt=0 -> no stall; with ID_UsesRt=1 -> stall.
- LOAD_LATENCY=3, hit at cycle 0 -> HazardMux=1 for cycles 0, 1, 2, and 0 at cycle 3; BranchTakenID=1 at cycle 1 -> IFIDFlush stays 0.
- LOAD_LATENCY=3, MemReqMem=1 and MemReadyMem=0 for 2 cycles during LU_STALL -> PipeFreeze=1, HazardMux=0 in those cycles; total HazardMux=1 cycles still 3.
- BranchTakenID=1 with no hit and no freeze -> IFIDFlush=1, PCWrite=1. The same with freeze=1 -> IFIDFlush=0, PipeFreeze=1.
- Reset pulsed during cycle 1 of a LOAD_LATENCY=4 stall -> outputs 1,1,0,0,0 immediately; after release, state is RUN. With HAZARD_PERF_CNT_EN defined, StallCycles=0 after reset.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Load-use hazard and stall controller for the 5-stage MIPS pipeline, sitting beside ID.
// Optional stall/freeze performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReadEx,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic                  BranchTakenID,
  input  logic                  MemReqMem,
  input  logic                  MemReadyMem,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  HazardMux,
  output logic                  IFIDFlush,
  output logic                  PipeFreeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           StallCycles,
  output logic [31:0]           FreezeCycles
`endif
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAT_M1    = CNT_W'(LOAD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               MULTI_LAT = (LOAD_LATENCY > 1);

  generate
    if ((LOAD_LATENCY < 1) || (LOAD_LATENCY > 15) ||
        ((LOAD_LATENCY - 1) >= (1 << CNT_W))) begin : g_bad_param
      $error("hazard_ctrl: LOAD_LATENCY out of range or CNT_W too narrow");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze_s;
  logic             hit_s;

  // Hazard qualifiers: register 0 never forwards a hazard, Rt only counts when read.
  always_comb begin
    freeze_s = MemReqMem & ~MemReadyMem;
    hit_s    = MemReadEx & (IDEX_Rt != {REG_ADDR_W{1'b0}}) &
               ((IDEX_Rt == ID_Rs) | (ID_UsesRt & (IDEX_Rt == ID_Rt)));
  end

  // Next-state and output decode; freeze outranks stall, stall outranks branch flush.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    HazardMux  = 1'b0;
    IFIDFlush  = 1'b0;
    PipeFreeze = 1'b0;
    if (reset) begin
      state_d = ST_RUN;
      cnt_d   = CNT_ZERO;
    end else if (freeze_s) begin
      PipeFreeze = 1'b1;
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hit_s) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            HazardMux = 1'b1;
            if (MULTI_LAT) begin
              state_d = ST_LU_STALL;
              cnt_d   = LAT_M1;
            end else begin
              state_d = ST_RUN;
              cnt_d   = CNT_ZERO;
            end
          end else begin
            IFIDFlush = BranchTakenID;
          end
        end
        ST_LU_STALL: begin
          // Branch outcome is based on stale operands here, so it is dropped.
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          HazardMux = 1'b1;
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_LU_STALL;
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and bubble counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] freeze_cycles_q, freeze_cycles_d;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    freeze_cycles_d = freeze_cycles_q;
    if (HazardMux && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (PipeFreeze && (freeze_cycles_q != 32'hFFFF_FFFF)) begin
      freeze_cycles_d = freeze_cycles_q + 32'd1;
    end else begin
      freeze_cycles_d = freeze_cycles_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q  <= 32'd0;
      freeze_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      freeze_cycles_q <= freeze_cycles_d;
    end
  end

  assign StallCycles  = stall_cycles_q;
  assign FreezeCycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LATENCY 1, 3, 4) share one stimulus stream
// and are compared every cycle against a bubbles-remaining reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemReadEx;
  logic [4:0] IDEX_Rt, ID_Rs, ID_Rt;
  logic       ID_UsesRt, BranchTakenID, MemReqMem, MemReadyMem;

  logic [4:0] outs [3];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_c [3];
  logic [31:0] frz_c   [3];
`endif

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  int     lat  [3] = '{1, 3, 4};
  int     rem  [3];
  int     hm_seen [3];
  longint m_stall [3];
  longint m_frz   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic pcw, ifw, hm, fl, pf;
    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(L), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .MemReadEx(MemReadEx), .IDEX_Rt(IDEX_Rt),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .BranchTakenID(BranchTakenID), .MemReqMem(MemReqMem), .MemReadyMem(MemReadyMem),
      .PCWrite(pcw), .IFIDWrite(ifw), .HazardMux(hm), .IFIDFlush(fl), .PipeFreeze(pf)
`ifdef HAZARD_PERF_CNT_EN
      , .StallCycles(stall_c[g]), .FreezeCycles(frz_c[g])
`endif
    );
    assign outs[g] = {pcw, ifw, hm, fl, pf};
  end

  // Expected {PCWrite, IFIDWrite, HazardMux, IFIDFlush, PipeFreeze} from the rules.
  function automatic logic [4:0] exp_out(int k);
    bit hit;
    hit = MemReadEx && (IDEX_Rt != 0) &&
          ((IDEX_Rt == ID_Rs) || (ID_UsesRt && (IDEX_Rt == ID_Rt)));
    if (reset)                         return 5'b11000;
    if (MemReqMem && !MemReadyMem)     return 5'b00001;
    if (rem[k] > 0 || hit)             return 5'b00100;
    return {1'b1, 1'b1, 1'b0, BranchTakenID, 1'b0};
  endfunction

  function automatic int next_rem(int k);
    bit hit;
    hit = MemReadEx && (IDEX_Rt != 0) &&
          ((IDEX_Rt == ID_Rs) || (ID_UsesRt && (IDEX_Rt == ID_Rt)));
    if (reset)                     return 0;
    if (MemReqMem && !MemReadyMem) return rem[k];
    if (rem[k] > 0)                return rem[k] - 1;
    if (hit)                       return lat[k] - 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [4:0] obs, input logic [4:0] ex);
    total++;
    assert (obs === ex) passed++;
    else begin
      fails++;
      $error("FAIL %s lat=%0d: observed %b expected %b", tag, lat[k], obs, ex);
    end
  endtask

  task automatic chk_n(input string tag, input int k, input longint obs, input longint ex);
    total++;
    assert (obs === ex) passed++;
    else begin
      fails++;
      $error("FAIL %s lat=%0d: observed %0d expected %0d", tag, lat[k], obs, ex);
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, check, advance model at the edge.
  task automatic step(input bit rs, input bit mre, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input bit ur, input bit br, input bit rq,
                      input bit rdy, input string tag);
    int       nrem [3];
    logic [4:0] e;
    reset = rs; MemReadEx = mre; IDEX_Rt = a; ID_Rs = b; ID_Rt = c;
    ID_UsesRt = ur; BranchTakenID = br; MemReqMem = rq; MemReadyMem = rdy;
    #3;
    for (int k = 0; k < 3; k++) begin
      e = exp_out(k);
      chk(tag, k, outs[k], e);
      hm_seen[k] += int'(outs[k][2]);
      if (rs) begin
        m_stall[k] = 0;
        m_frz[k]   = 0;
      end
`ifdef HAZARD_PERF_CNT_EN
      chk_n({tag, "_stallcnt"}, k, longint'(stall_c[k]), m_stall[k]);
      chk_n({tag, "_frzcnt"}, k, longint'(frz_c[k]), m_frz[k]);
`endif
      nrem[k] = next_rem(k);
      if (!rs) begin
        m_stall[k] += longint'(e[2]);
        m_frz[k]   += longint'(e[0]);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rem[k] = nrem[k];
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; hm_seen[k] = 0; m_stall[k] = 0; m_frz[k] = 0;
    end
    reset = 1'b1; MemReadEx = 1'b1; IDEX_Rt = 5'd8; ID_Rs = 5'd8; ID_Rt = 5'd0;
    ID_UsesRt = 1'b0; BranchTakenID = 1'b1; MemReqMem = 1'b1; MemReadyMem = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("reset_forced", k, outs[k], 5'b11000);
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "reset_hold");
    idle(1, "idle");

    // Basic load-use on Rs, then the load leaves EX.
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, "lu_hit");
    step(1'b0, 1'b0, 5'd8, 5'd8, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, "lu_after");
    idle(4, "drain");

    // Register 0 and Rt qualification.
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, "r0_nohaz");
    step(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, "rt_unused");
    step(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, "rt_used");
    idle(4, "drain");

    // Taken branch during a stall is dropped; count bubbles per hazard.
    for (int k = 0; k < 3; k++) hm_seen[k] = 0;
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "br_stall_hit");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, "br_in_stall");
    idle(4, "drain");
    for (int k = 0; k < 3; k++) chk_n("bubbles_nofrz", k, longint'(hm_seen[k]), longint'(lat[k]));

    // Freeze in the middle of a stall consumes no count.
    for (int k = 0; k < 3; k++) hm_seen[k] = 0;
    step(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "frz_hit");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "frz_1");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "frz_2");
    idle(5, "drain");
    for (int k = 0; k < 3; k++) chk_n("bubbles_frz", k, longint'(hm_seen[k]), longint'(lat[k]));

    // Branch flush alone and under freeze.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, "br_flush");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, "br_freeze");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, "br_mem_ready");

    // Back-to-back hazards.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b");
    idle(4, "drain");

    // Reset in cycle 1 of a stall.
    step(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_hit");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_cyc1");
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk("rst_async", k, outs[k], 5'b11000);
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; m_stall[k] = 0; m_frz[k] = 0;
    end
`ifdef HAZARD_PERF_CNT_EN
    for (int k = 0; k < 3; k++) chk_n("rst_stallcnt", k, longint'(stall_c[k]), 0);
`endif
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

    // Randomized traffic on a small register set so hazards are common.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 50),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 60), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
